anotherworld_page_engine: RTL and testbench
===========================================

ANOTHERWORLD_PAGE_ENGINE -- requirements
Module: anotherworld_page_engine

Interface
REQ-001 Parameter WORDS_PER_PAGE, default 16000, 16-bit words per video page (320x200 pixels, 4 bpp, 4 pixels/word).
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cmd_valid  input  1  command offered by VM core (fillVideoPage / copyVideoPage).
REQ-005 cmd_ready  output  1  engine can accept a command.
REQ-006 cmd_op  input  1  0 = fill, 1 = copy.
REQ-007 cmd_dst  input  2  destination page index.
REQ-008 cmd_src  input  2  source page index (copy only).
REQ-009 cmd_color  input  4  palette index (fill only).
REQ-010 fb_addr  output  16  framebuffer word address = {page[1:0], offset[13:0]}.
REQ-011 fb_we  output  1  write strobe; fb_wdata valid same cycle.
REQ-012 fb_wdata  output  16  write data.
REQ-013 fb_re  output  1  read strobe.
REQ-014 fb_rdata  input  16  read data, valid exactly one cycle after fb_re.
REQ-015 busy  output  1  high while a command executes.
REQ-016 done  output  1  one-cycle pulse on command completion.

Function
REQ-017 Command accepted on a cycle with cmd_valid && cmd_ready; all cmd_* fields latched that cycle.
REQ-018 cmd_ready = 1 only in IDLE; busy = !cmd_ready.
REQ-019 States: IDLE, FILL, COPY_RD, COPY_WR, DONE.
REQ-020 IDLE -> FILL (op 0), COPY_RD (op 1, src != dst), DONE (op 1, src == dst, no memory access).
REQ-021 FILL: one write per cycle, offset 0..WORDS_PER_PAGE-1 ascending, fb_wdata = color replicated in all four nibbles.
REQ-022 FILL first write occurs the cycle after acceptance; after offset WORDS_PER_PAGE-1 -> DONE.
REQ-023 COPY_RD: fb_re=1, fb_addr={src,offset}; next state COPY_WR.
REQ-024 COPY_WR: fb_we=1, fb_addr={dst,offset}, fb_wdata=fb_rdata; offset+1; -> COPY_RD, or DONE after last offset.
REQ-025 Copy takes 2*WORDS_PER_PAGE memory cycles; fill takes WORDS_PER_PAGE.
REQ-026 DONE: done=1 for one cycle, -> IDLE; new command accepted no earlier than the following cycle.
REQ-027 fb_we and fb_re never both high; both low in IDLE and DONE; fb_addr/fb_wdata don't-care when strobes low.
REQ-028 Offset counter 14 bits, never exceeds WORDS_PER_PAGE-1; no wrap into adjacent page.
REQ-029 cmd_* changes while busy are ignored.

Reset
REQ-030 reset forces IDLE, offset=0, cmd_ready=1, busy=0, done=0, fb_we=0, fb_re=0, fb_addr=0, fb_wdata=0.
REQ-031 reset mid-command aborts immediately: no further fb strobes, no done pulse.
REQ-032 reset has priority over command acceptance in the same cycle.

Configuration
REQ-033 Macro ANOTHERWORLD_PAGECOPY_EN defined: copy supported as above.
REQ-034 Macro undefined: COPY_RD/COPY_WR omitted; op 1 accepted, no memory access, done pulse the cycle after acceptance.

Structure
REQ-035 Shared package holds opcode constants (0x0E fill, 0x0F copy), state encoding, WORDS_PER_PAGE default, page address width constants.
REQ-036 No sub-module; single FSM plus offset counter.

Verification
REQ-037 Fill: op0, dst=2, color=0xA -> 16000 writes addr 0x8000..0xBE7F, data 0xAAAA, done pulse 16001 cycles after accept.
REQ-038 Copy: preload page 1 with data=offset, op1 src=1 dst=3 -> page 3 word k == k for all k, 32000 memory cycles, no page-1 writes.
REQ-039 Copy src=dst=0 -> no fb_re/fb_we, done pulse cycle after accept.
REQ-040 reset asserted at fill offset 500 -> no strobes thereafter, no done, cmd_ready=1 next cycle; words 500+ untouched.
REQ-041 cmd_valid held high with changing fields during busy -> only first command executed; second accepted cycle after done.
REQ-042 Macro undefined: op1 src=1 dst=2 -> zero memory accesses, done one cycle after accept.

Source files
------------

// File: rtl/anotherworld_page_engine_pkg.sv
// Shared constants for the video page engine: VM opcodes, FSM encoding and
// framebuffer address geometry.
package anotherworld_page_engine_pkg;

    localparam logic [7:0] OPCODE_FILL = 8'h0E;
    localparam logic [7:0] OPCODE_COPY = 8'h0F;

    // The engine's cmd_op bit is the low bit of the VM opcode.
    localparam logic CMD_OP_FILL = OPCODE_FILL[0];
    localparam logic CMD_OP_COPY = OPCODE_COPY[0];

    localparam int WORDS_PER_PAGE_DEF = 16000;
    localparam int PAGE_W             = 2;
    localparam int OFFSET_W           = 14;
    localparam int ADDR_W             = PAGE_W + OFFSET_W;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FILL    = 3'd1,
        ST_COPY_RD = 3'd2,
        ST_COPY_WR = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    function automatic logic [15:0] fill_word(input logic [3:0] color);
        return {4{color}};
    endfunction

endpackage

// File: rtl/anotherworld_page_engine.sv
// Video page fill/copy engine; fill = WORDS_PER_PAGE write cycles, copy = 2*WORDS_PER_PAGE read/write cycles.
// Latency: first strobe the cycle after accept, done pulse one cycle after the last write.
// Backpressure: cmd_ready only in IDLE; copy support built only with ANOTHERWORLD_PAGECOPY_EN.
module anotherworld_page_engine
    import anotherworld_page_engine_pkg::*;
#(
    parameter int WORDS_PER_PAGE = WORDS_PER_PAGE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [1:0]  cmd_dst,
    input  logic [1:0]  cmd_src,
    input  logic [3:0]  cmd_color,
    output logic [15:0] fb_addr,
    output logic        fb_we,
    output logic [15:0] fb_wdata,
    output logic        fb_re,
    input  logic [15:0] fb_rdata,
    output logic        busy,
    output logic        done
);

    localparam logic [OFFSET_W-1:0] OFFSET_LAST = OFFSET_W'(WORDS_PER_PAGE - 1);
    localparam logic [OFFSET_W-1:0] OFFSET_ZERO = '0;

    state_t              state;
    logic [OFFSET_W-1:0] offset;
    logic [OFFSET_W-1:0] offset_nxt;
    logic [PAGE_W-1:0]   dst_q;
    logic [15:0]         fill_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic                re_q;
    logic                done_q;

`ifdef ANOTHERWORLD_PAGECOPY_EN
    logic [PAGE_W-1:0]   src_q;
`endif

    assign offset_nxt = offset + 14'd1;
    assign cmd_ready  = (state == ST_IDLE);
    assign busy       = ~cmd_ready;
    assign done       = done_q;
    assign fb_addr    = addr_q;
    // Strobes are cut combinationally so a reset aborts the in-flight access too.
    assign fb_we      = we_q & ~reset;
    assign fb_re      = re_q & ~reset;

`ifdef ANOTHERWORLD_PAGECOPY_EN
    // Read data arrives in the COPY_WR cycle and is written straight through.
    assign fb_wdata = (state == ST_COPY_WR) ? fb_rdata : fill_q;
`else
    logic unused_copy;
    assign unused_copy = ^{cmd_src, fb_rdata};
    assign fb_wdata    = fill_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            offset <= '0;
            dst_q  <= '0;
            fill_q <= '0;
            addr_q <= '0;
            we_q   <= 1'b0;
            re_q   <= 1'b0;
            done_q <= 1'b0;
`ifdef ANOTHERWORLD_PAGECOPY_EN
            src_q  <= '0;
`endif
        end else begin
            we_q   <= 1'b0;
            re_q   <= 1'b0;
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        dst_q  <= cmd_dst;
                        fill_q <= fill_word(cmd_color);
                        offset <= '0;
`ifdef ANOTHERWORLD_PAGECOPY_EN
                        src_q  <= cmd_src;
`endif
                        if (cmd_op == CMD_OP_FILL) begin
                            state  <= ST_FILL;
                            we_q   <= 1'b1;
                            addr_q <= {cmd_dst, OFFSET_ZERO};
                        end
`ifdef ANOTHERWORLD_PAGECOPY_EN
                        else if (cmd_src != cmd_dst) begin
                            state  <= ST_COPY_RD;
                            re_q   <= 1'b1;
                            addr_q <= {cmd_src, OFFSET_ZERO};
                        end
`endif
                        else begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_FILL: begin
                    if (offset == OFFSET_LAST) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                    end else begin
                        offset <= offset_nxt;
                        we_q   <= 1'b1;
                        addr_q <= {dst_q, offset_nxt};
                    end
                end
`ifdef ANOTHERWORLD_PAGECOPY_EN
                ST_COPY_RD: begin
                    state  <= ST_COPY_WR;
                    we_q   <= 1'b1;
                    addr_q <= {dst_q, offset};
                end
                ST_COPY_WR: begin
                    if (offset == OFFSET_LAST) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                    end else begin
                        offset <= offset_nxt;
                        state  <= ST_COPY_RD;
                        re_q   <= 1'b1;
                        addr_q <= {src_q, offset_nxt};
                    end
                end
`endif
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_anotherworld_page_engine.sv
// Directed bench for the page engine: a command table plus hand-written hold and
// mid-command reset sequences against a framebuffer model with 1-cycle read latency.
module tb_anotherworld_page_engine;

    localparam int WPP = 16000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_op = 1'b0;
    logic [1:0]  cmd_dst = 2'd0;
    logic [1:0]  cmd_src = 2'd0;
    logic [3:0]  cmd_color = 4'd0;
    logic [15:0] fb_rdata = 16'd0;
    wire         cmd_ready, fb_we, fb_re, busy, done;
    wire  [15:0] fb_addr, fb_wdata;

    anotherworld_page_engine #(.WORDS_PER_PAGE(WPP)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_color(cmd_color),
        .fb_addr(fb_addr), .fb_we(fb_we), .fb_wdata(fb_wdata),
        .fb_re(fb_re), .fb_rdata(fb_rdata), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Framebuffer model: unwritten page-1 words read back as their offset, others as 0.
    logic [15:0] mem [0:65535];
    bit          written [0:65535];

    function automatic logic [15:0] rd(input logic [15:0] a);
        if (written[a]) return mem[a];
        return (a[15:14] == 2'd1) ? {2'b00, a[13:0]} : 16'h0000;
    endfunction

    function automatic logic [15:0] page_addr(input logic [1:0] p, input int k);
        return {p, 14'(k)};
    endfunction

    int cyc = 0, arm_tok = 0, arm_seen = 0;
    int wcnt = 0, rcnt = 0, both = 0, pg1w = 0, outw = 0;
    int acc_cnt = 0, acc_cyc = 0, done_cnt = 0, done_cyc = 0;
    int first_w_cyc = 0, first_w_addr = 0, last_w_addr = 0;
    logic [1:0] exp_dst = 2'd0;

    always @(posedge clk) begin
        if (arm_tok != arm_seen) begin
            arm_seen = arm_tok;
            wcnt = 0; rcnt = 0; both = 0; pg1w = 0; outw = 0;
            acc_cnt = 0; acc_cyc = 0; done_cnt = 0; done_cyc = 0;
            first_w_cyc = -1; first_w_addr = 0; last_w_addr = 0;
        end
        if (cmd_valid && cmd_ready && !reset) begin
            acc_cnt++;
            acc_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (fb_we && fb_re) both++;
        if (fb_we) begin
            if (wcnt == 0) begin
                first_w_cyc  = cyc;
                first_w_addr = int'(fb_addr);
            end
            last_w_addr = int'(fb_addr);
            wcnt++;
            if (fb_addr[15:14] == 2'd1) pg1w++;
            if (fb_addr[15:14] != exp_dst) outw++;
            mem[fb_addr]     <= fb_wdata;
            written[fb_addr] <= 1'b1;
        end
        if (fb_re) begin
            rcnt++;
            fb_rdata <= rd(fb_addr);
        end
        cyc++;
    end

    int checks = 0, failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic arm();
        arm_tok++;
        @(negedge clk);
    endtask

    task automatic issue(input logic op, input logic [1:0] dst, input logic [1:0] src,
                         input logic [3:0] color);
        int n;
        cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_color = color;
        cmd_valid = 1'b1;
        n = 0;
        while (acc_cnt == 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        cmd_valid = 1'b0;
        chk("accept", acc_cnt, 1);
    endtask

    task automatic wait_done(input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done_cnt, target);
    endtask

    typedef struct {
        logic       op;
        logic [1:0] dst;
        logic [1:0] src;
        logic [3:0] color;
        int         lat;
        int         n_we;
        int         n_re;
        int         first_lat;
        int         first_addr;
        int         last_addr;
    } vec_t;

    vec_t vt [4];

    initial begin
        int bad, n, d1, ws, ds, as_;

        vt[0] = '{1'b0, 2'd2, 2'd0, 4'hA, 16001, 16000, 0, 1, 'h8000, 'hBE7F};
`ifdef ANOTHERWORLD_PAGECOPY_EN
        vt[1] = '{1'b1, 2'd3, 2'd1, 4'h0, 32001, 16000, 16000, 2, 'hC000, 'hFE7F};
        vt[3] = '{1'b1, 2'd2, 2'd2, 4'h5, 1, 0, 0, 0, 0, 0};
`else
        vt[1] = '{1'b1, 2'd3, 2'd1, 4'h0, 1, 0, 0, 0, 0, 0};
        vt[3] = '{1'b1, 2'd2, 2'd1, 4'h5, 1, 0, 0, 0, 0, 0};
`endif
        vt[2] = '{1'b1, 2'd0, 2'd0, 4'h9, 1, 0, 0, 0, 0, 0};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_fb_we", int'(fb_we), 0);
        chk("rst_fb_re", int'(fb_re), 0);
        chk("rst_fb_addr", int'(fb_addr), 0);
        chk("rst_fb_wdata", int'(fb_wdata), 0);

        for (int i = 0; i < 4; i++) begin
            exp_dst = vt[i].dst;
            arm();
            issue(vt[i].op, vt[i].dst, vt[i].src, vt[i].color);
            wait_done(1, 40000);
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d_latency", i), done_cyc - acc_cyc, vt[i].lat);
            chk($sformatf("v%0d_writes", i), wcnt, vt[i].n_we);
            chk($sformatf("v%0d_reads", i), rcnt, vt[i].n_re);
            chk($sformatf("v%0d_we_and_re", i), both, 0);
            chk($sformatf("v%0d_page1_writes", i), pg1w, 0);
            chk($sformatf("v%0d_foreign_page_writes", i), outw, 0);
            chk($sformatf("v%0d_single_done", i), done_cnt, 1);
            chk($sformatf("v%0d_ready_after", i), int'(cmd_ready), 1);
            if (vt[i].n_we > 0) begin
                chk($sformatf("v%0d_first_write_lat", i), first_w_cyc - acc_cyc, vt[i].first_lat);
                chk($sformatf("v%0d_first_addr", i), first_w_addr, vt[i].first_addr);
                chk($sformatf("v%0d_last_addr", i), last_w_addr, vt[i].last_addr);
            end
        end

        bad = 0;
        for (int k = 0; k < WPP; k++) if (rd(page_addr(2'd2, k)) !== 16'hAAAA) bad++;
        chk("page2_fill_words_bad", bad, 0);
        bad = 0;
        for (int k = 0; k < WPP; k++) if (rd(page_addr(2'd1, k)) !== 16'(k)) bad++;
        chk("page1_untouched_bad", bad, 0);
        bad = 0;
`ifdef ANOTHERWORLD_PAGECOPY_EN
        for (int k = 0; k < WPP; k++) if (rd(page_addr(2'd3, k)) !== 16'(k)) bad++;
`else
        for (int k = 0; k < WPP; k++) if (rd(page_addr(2'd3, k)) !== 16'h0000) bad++;
`endif
        chk("page3_words_bad", bad, 0);

        // cmd_valid held with wandering fields while busy
        exp_dst = 2'd0;
        arm();
        cmd_op = 1'b0; cmd_dst = 2'd0; cmd_src = 2'd0; cmd_color = 4'h3;
        cmd_valid = 1'b1;
        n = 0;
        while (acc_cnt == 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("hold_first_accept", acc_cnt, 1);
        d1 = -1000;
        n = 0;
        while (d1 < 0 && n < 20000) begin
            @(negedge clk);
            n++;
            if (done) begin
                d1 = cyc;
                cmd_op = 1'b1; cmd_dst = 2'd2; cmd_src = 2'd2;
            end else begin
                cmd_op    = 1'($urandom_range(0, 1));
                cmd_dst   = 2'($urandom_range(0, 3));
                cmd_src   = 2'($urandom_range(0, 3));
                cmd_color = 4'($urandom_range(0, 15));
            end
        end
        n = 0;
        while (acc_cnt < 2 && n < 10) begin
            @(negedge clk);
            n++;
        end
        cmd_valid = 1'b0;
        chk("hold_accept_count", acc_cnt, 2);
        chk("hold_second_accept_gap", acc_cyc - d1, 1);
        wait_done(2, 10);
        repeat (2) @(negedge clk);
        chk("hold_writes", wcnt, WPP);
        chk("hold_reads", rcnt, 0);
        chk("hold_foreign_page_writes", outw, 0);
        bad = 0;
        for (int k = 0; k < WPP; k++) if (rd(page_addr(2'd0, k)) !== 16'h3333) bad++;
        chk("hold_page0_bad", bad, 0);

        // reset while the fill presents offset 500
        exp_dst = 2'd0;
        arm();
        issue(1'b0, 2'd0, 2'd0, 4'hC);
        n = 0;
        while (!(fb_we && fb_addr == 16'd500) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach_offset_500", int'(fb_we && fb_addr == 16'd500), 1);
        reset = 1'b1;
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_dst = 2'd1; cmd_color = 4'h7;
        #1;
        chk("abort_fb_we", int'(fb_we), 0);
        chk("abort_fb_re", int'(fb_re), 0);
        ws = wcnt; ds = done_cnt; as_ = acc_cnt;
        @(negedge clk);
        reset = 1'b0;
        cmd_valid = 1'b0;
        chk("abort_cmd_ready", int'(cmd_ready), 1);
        chk("abort_busy_reset_priority", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        repeat (20) @(negedge clk);
        chk("abort_writes_before", ws, 500);
        chk("abort_writes_after", wcnt, ws);
        chk("abort_no_done", done_cnt, ds);
        chk("abort_no_accept", acc_cnt, as_);
        bad = 0;
        for (int k = 0; k < 500; k++) if (rd(page_addr(2'd0, k)) !== 16'hCCCC) bad++;
        chk("abort_head_bad", bad, 0);
        bad = 0;
        for (int k = 500; k < WPP; k++) if (rd(page_addr(2'd0, k)) !== 16'h3333) bad++;
        chk("abort_tail_bad", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
